// File: rtl/seq_mult_ctrl.sv
// Sequential shift-and-add unsigned multiplier controller built around one AdderAnybits instance.
// Optional: define SEQ_MULT_ZERO_SKIP_EN so that a zero operand completes in one cycle.

module AdderAnybits #(
  parameter int unsigned width = 8
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] s,
  output logic             cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b};
endmodule

module seq_mult_ctrl #(
  parameter int unsigned width = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [width-1:0]     A,
  input  logic [width-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*width-1:0]   P
);

  localparam int unsigned CW = $clog2(width + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [width-1:0] m, q, acc;
  logic [width-1:0] add_b, sum;
  logic             cout;
  logic [CW-1:0]    cnt;
  logic             last_step;
  logic             zero_op;

  // Partial product is the multiplicand gated by the current multiplier LSB.
  assign add_b     = q[0] ? m : '0;
  assign last_step = (cnt == CW'(1));

  AdderAnybits #(.width(width)) u_adder (
    .a    (acc),
    .b    (add_b),
    .s    (sum),
    .cout (cout)
  );

`ifdef SEQ_MULT_ZERO_SKIP_EN
  assign zero_op = (A == '0) || (B == '0);
`else
  assign zero_op = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = zero_op ? DONE : RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register, registered status flags and datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      P     <= '0;
      m     <= '0;
      q     <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      done  <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            m   <= A;
            q   <= B;
            acc <= '0;
            cnt <= CW'(width);
            if (zero_op) P <= '0;
          end
        end
        RUN: begin
          // Carry-out enters the accumulator MSB as {ACC,Q} shifts right.
          acc <= {cout, sum[width-1:1]};
          q   <= {sum[0], q[width-1:1]};
          cnt <= cnt - CW'(1);
          if (last_step) P <= {cout, sum, q[width-1:1]};
        end
        default: ;
      endcase
    end
  end

endmodule
